// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM->WB handshake bundle.
//   master (MEM stage): drives ms_valid and the ms_* instruction fields, samples ws_allowin
//   slave  (WB stage) : samples ms_valid and the ms_* fields, drives ws_allowin
interface wb_stage_if;
    logic        ms_valid;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        ms_is_load;
    logic [2:0]  ms_load_op;
    logic [1:0]  ms_addr_lo;
    logic        ws_allowin;
    modport master (
        output ms_valid, ms_pc, ms_rf_we, ms_dest, ms_result, ms_is_load, ms_load_op, ms_addr_lo,
        input  ws_allowin
    );
    modport slave (
        input  ms_valid, ms_pc, ms_rf_we, ms_dest, ms_result, ms_is_load, ms_load_op, ms_addr_lo,
        output ws_allowin
    );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back stage; aligns load data and drives the GPR write port and decode bypass.
//   clk, rst            : clock, synchronous active-high reset
//   ms                  : MEM->WB handshake (wb_stage_if.slave)
//   data_rvalid_i/rdata : load read beat
//   rf_we/waddr/wdata_o : register-file write port
//   ws_fwd_*_o          : bypass to decode (pending = value not yet valid, load still waiting)
//   WB_DEBUG_TRACE_EN   : when defined, adds debug_wb_pc/rf_wen/rf_wnum/rf_wdata outputs
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   ms,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        ws_fwd_valid_o,
    output logic [4:0]  ws_fwd_dest_o,
    output logic [31:0] ws_fwd_data_o,
    output logic        ws_fwd_pending_o
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc_o,
    output logic [3:0]  debug_wb_rf_wen_o,
    output logic [4:0]  debug_wb_rf_wnum_o,
    output logic [31:0] debug_wb_rf_wdata_o
`endif
);
    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] result_q, result_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  load_op_q, load_op_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic        ws_valid, allowin, accept, rv_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // Valid is implied by any non-empty state.
    assign ws_valid = state_q != S_EMPTY;
    assign allowin  = !ws_valid || state_q != S_WAIT;
    assign ms.ws_allowin = allowin;
    assign accept   = ms.ms_valid && allowin;
    // Read data only counts while a load is actually waiting; the acceptance cycle is excluded.
    assign rv_hit   = state_q == S_WAIT && is_load_q && data_rvalid_i;

    assign byte_sel  = data_rdata_i[{addr_lo_q, 3'b000} +: 8];
    assign half_sel  = addr_lo_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    assign load_data = load_op_q == 3'd1 ? {{24{byte_sel[7]}}, byte_sel} :
                       load_op_q == 3'd2 ? {24'b0, byte_sel} :
                       load_op_q == 3'd3 ? {{16{half_sel[15]}}, half_sel} :
                       load_op_q == 3'd4 ? {16'b0, half_sel} : data_rdata_i;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rf_we_d   = rf_we_q;
        dest_d    = dest_q;
        result_d  = result_q;
        is_load_d = is_load_q;
        load_op_d = load_op_q;
        addr_lo_d = addr_lo_q;
        if (accept) begin
            state_d   = ms.ms_is_load ? S_WAIT : S_DONE;
            pc_d      = ms.ms_pc;
            rf_we_d   = ms.ms_rf_we;
            dest_d    = ms.ms_dest;
            result_d  = ms.ms_result;
            is_load_d = ms.ms_is_load;
            load_op_d = ms.ms_load_op;
            addr_lo_d = ms.ms_addr_lo;
        end else if (rv_hit) begin
            state_d  = S_DONE;
            result_d = load_data;
        end else if (state_q == S_DONE) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            pc_q      <= '0;
            rf_we_q   <= 1'b0;
            dest_q    <= '0;
            result_q  <= '0;
            is_load_q <= 1'b0;
            load_op_q <= '0;
            addr_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rf_we_q   <= rf_we_d;
            dest_q    <= dest_d;
            result_q  <= result_d;
            is_load_q <= is_load_d;
            load_op_q <= load_op_d;
            addr_lo_q <= addr_lo_d;
        end
    end

    assign ws_fwd_valid_o   = ws_valid && rf_we_q && dest_q != 5'd0;
    assign ws_fwd_pending_o = ws_fwd_valid_o && state_q == S_WAIT;
    assign ws_fwd_dest_o    = dest_q;
    assign ws_fwd_data_o    = result_q;
    assign rf_we_o          = ws_valid && state_q == S_DONE && rf_we_q && dest_q != 5'd0;
    assign rf_waddr_o       = dest_q;
    assign rf_wdata_o       = result_q;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc_o       = pc_q;
    assign debug_wb_rf_wen_o   = {4{rf_we_o}};
    assign debug_wb_rf_wnum_o  = rf_waddr_o;
    assign debug_wb_rf_wdata_o = rf_wdata_o;
`else
    // PC is only observable through the trace port.
    logic unused_pc;
    assign unused_pc = ^pc_q;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vector bench for wb_stage.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic        fwd_pending;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] dbg_pc;
    logic [3:0]  dbg_wen;
    logic [4:0]  dbg_wnum;
    logic [31:0] dbg_wdata;
`endif
    int total = 0;
    int bad = 0;

    wb_stage_if ms();

    wb_stage dut (
        .clk(clk), .rst(rst), .ms(ms),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .ws_fwd_valid_o(fwd_valid), .ws_fwd_dest_o(fwd_dest),
        .ws_fwd_data_o(fwd_data), .ws_fwd_pending_o(fwd_pending)
`ifdef WB_DEBUG_TRACE_EN
        , .debug_wb_pc_o(dbg_pc), .debug_wb_rf_wen_o(dbg_wen),
        .debug_wb_rf_wnum_o(dbg_wnum), .debug_wb_rf_wdata_o(dbg_wdata)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        ld;
        logic [2:0]  op;
        logic [1:0]  lo;
        logic [4:0]  dst;
        logic        we;
        logic [31:0] res;
        logic        rv;
        logic [31:0] rd;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_allow;
        logic        e_fv;
        logic        e_fp;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic ld, input logic [2:0] op,
                         input logic [1:0] lo, input logic [4:0] dst, input logic we,
                         input logic [31:0] res, input logic rv, input logic [31:0] rd);
        rst = r;
        ms.ms_valid = v;
        ms.ms_pc = {27'h0, dst};
        ms.ms_is_load = ld;
        ms.ms_load_op = op;
        ms.ms_addr_lo = lo;
        ms.ms_dest = dst;
        ms.ms_rf_we = we;
        ms.ms_result = res;
        data_rvalid = rv;
        data_rdata = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        drive(r, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic chk_state(input string tag, input logic we, input logic allow,
                             input logic fv, input logic fp);
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(we));
        chk({tag, ".allowin"}, 32'(ms.ws_allowin), 32'(allow));
        chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(fv));
        chk({tag, ".fwd_pending"}, 32'(fwd_pending), 32'(fp));
    endtask

    initial begin
        //            v     ld    op    lo    dst    we    res            rv    rd             e_we  e_addr e_data        allow fv    fp
        vq.push_back('{1'b1,1'b0,3'd0,2'd0,5'd5, 1'b1,32'h12345678,1'b0,32'h0,        1'b1,5'd5, 32'h12345678,1'b1,1'b1,1'b0});
        vq.push_back('{1'b0,1'b0,3'd0,2'd0,5'd0, 1'b0,32'h0,       1'b0,32'h0,        1'b0,5'd5, 32'h12345678,1'b1,1'b0,1'b0});
        vq.push_back('{1'b1,1'b1,3'd1,2'd3,5'd7, 1'b1,32'hAAAAAAAA,1'b1,32'h00000011,1'b0,5'd7, 32'hAAAAAAAA,1'b0,1'b1,1'b1});
        vq.push_back('{1'b1,1'b0,3'd0,2'd0,5'd9, 1'b1,32'h99999999,1'b0,32'h0,        1'b0,5'd7, 32'hAAAAAAAA,1'b0,1'b1,1'b1});
        vq.push_back('{1'b0,1'b0,3'd0,2'd0,5'd0, 1'b0,32'h0,       1'b0,32'h0,        1'b0,5'd7, 32'hAAAAAAAA,1'b0,1'b1,1'b1});
        vq.push_back('{1'b0,1'b0,3'd0,2'd0,5'd0, 1'b0,32'h0,       1'b1,32'h80FFFFFF,1'b1,5'd7, 32'hFFFFFF80,1'b1,1'b1,1'b0});
        vq.push_back('{1'b1,1'b1,3'd4,2'd2,5'd8, 1'b1,32'h0,       1'b0,32'h0,        1'b0,5'd8, 32'h0,       1'b0,1'b1,1'b1});
        vq.push_back('{1'b0,1'b0,3'd0,2'd0,5'd0, 1'b0,32'h0,       1'b1,32'h80010000,1'b1,5'd8, 32'h00008001,1'b1,1'b1,1'b0});
        vq.push_back('{1'b1,1'b1,3'd0,2'd0,5'd9, 1'b1,32'h0,       1'b0,32'h0,        1'b0,5'd9, 32'h0,       1'b0,1'b1,1'b1});
        vq.push_back('{1'b0,1'b0,3'd0,2'd0,5'd0, 1'b0,32'h0,       1'b1,32'hDEADBEEF,1'b1,5'd9, 32'hDEADBEEF,1'b1,1'b1,1'b0});
        vq.push_back('{1'b1,1'b0,3'd0,2'd0,5'd3, 1'b1,32'h00000003,1'b0,32'h0,        1'b1,5'd3, 32'h00000003,1'b1,1'b1,1'b0});
        vq.push_back('{1'b1,1'b0,3'd0,2'd0,5'd4, 1'b1,32'h00000004,1'b0,32'h0,        1'b1,5'd4, 32'h00000004,1'b1,1'b1,1'b0});
        vq.push_back('{1'b1,1'b0,3'd0,2'd0,5'd0, 1'b1,32'h00000055,1'b0,32'h0,        1'b0,5'd0, 32'h00000055,1'b1,1'b0,1'b0});
        vq.push_back('{1'b0,1'b0,3'd0,2'd0,5'd0, 1'b0,32'h0,       1'b0,32'h0,        1'b0,5'd0, 32'h00000055,1'b1,1'b0,1'b0});
        vq.push_back('{1'b1,1'b1,3'd3,2'd2,5'd10,1'b1,32'h0,       1'b0,32'h0,        1'b0,5'd10,32'h0,       1'b0,1'b1,1'b1});
        vq.push_back('{1'b0,1'b0,3'd0,2'd0,5'd0, 1'b0,32'h0,       1'b1,32'h80011234,1'b1,5'd10,32'hFFFF8001,1'b1,1'b1,1'b0});
        vq.push_back('{1'b1,1'b1,3'd2,2'd1,5'd11,1'b1,32'h0,       1'b0,32'h0,        1'b0,5'd11,32'h0,       1'b0,1'b1,1'b1});
        vq.push_back('{1'b0,1'b0,3'd0,2'd0,5'd0, 1'b0,32'h0,       1'b1,32'h0000F000,1'b1,5'd11,32'h000000F0,1'b1,1'b1,1'b0});
        vq.push_back('{1'b1,1'b1,3'd6,2'd1,5'd12,1'b1,32'h0,       1'b0,32'h0,        1'b0,5'd12,32'h0,       1'b0,1'b1,1'b1});
        vq.push_back('{1'b0,1'b0,3'd0,2'd0,5'd0, 1'b0,32'h0,       1'b1,32'h12345678,1'b1,5'd12,32'h12345678,1'b1,1'b1,1'b0});
        vq.push_back('{1'b1,1'b1,3'd1,2'd0,5'd13,1'b1,32'h0,       1'b0,32'h0,        1'b0,5'd13,32'h0,       1'b0,1'b1,1'b1});
        vq.push_back('{1'b0,1'b0,3'd0,2'd0,5'd0, 1'b0,32'h0,       1'b1,32'h0000007F,1'b1,5'd13,32'h0000007F,1'b1,1'b1,1'b0});
        vq.push_back('{1'b1,1'b0,3'd0,2'd0,5'd6, 1'b0,32'h00000066,1'b0,32'h0,        1'b0,5'd6, 32'h00000066,1'b1,1'b0,1'b0});

        idle(1'b1);
        chk_state("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset.waddr", 32'(rf_waddr), 32'h0);
        chk("reset.wdata", rf_wdata, 32'h0);
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            chk_state($sformatf("idle%0d", i), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        for (int i = 0; i < vq.size(); i++) begin
            drive(1'b0, vq[i].v, vq[i].ld, vq[i].op, vq[i].lo, vq[i].dst, vq[i].we,
                  vq[i].res, vq[i].rv, vq[i].rd);
            chk_state($sformatf("vec%0d", i), vq[i].e_we, vq[i].e_allow, vq[i].e_fv, vq[i].e_fp);
            chk($sformatf("vec%0d.waddr", i), 32'(rf_waddr), 32'(vq[i].e_addr));
            chk($sformatf("vec%0d.wdata", i), rf_wdata, vq[i].e_data);
            chk($sformatf("vec%0d.fwd_data", i), fwd_data, vq[i].e_data);
            chk($sformatf("vec%0d.fwd_dest", i), 32'(fwd_dest), 32'(vq[i].e_addr));
        end

        // Reset while a load waits, colliding with a new request and a read beat.
        drive(1'b0, 1'b1, 1'b1, 3'd0, 2'd0, 5'd14, 1'b1, 32'h0, 1'b0, 32'h0);
        chk_state("rstwait.load", 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd15, 1'b1, 32'hCAFEF00D, 1'b1, 32'h11111111);
        chk_state("rstwait.rst", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rstwait.wdata", rf_wdata, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h22222222);
        chk_state("rstwait.rv", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rstwait.rv.wdata", rf_wdata, 32'h0);
        idle(1'b0);
        chk_state("rstwait.idle", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
